// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module : reg_file_pkg
// Shared types and sizing for the integer register file and its scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;
   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int ADDR_W = $clog2(NREGS);

   typedef logic [ADDR_W-1:0] rs_addr_t;
   typedef logic [XLEN-1:0]   xdata_t;

   localparam rs_addr_t REG_ZERO = '0;

   function automatic logic is_zero_reg(rs_addr_t a);
      return a == REG_ZERO;
   endfunction
endpackage

`default_nettype wire

// File: rtl/reg_file_if.sv
// ============================================================================
// Module : reg_file_if
// Decode/writeback-side bundle of the register file: write, read, issue ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_file_if;
   import reg_file_pkg::*;

   logic     wb_en;
   rs_addr_t wb_addr;
   xdata_t   wb_data;
   rs_addr_t rs1_addr;
   logic     rs1_used;
   xdata_t   rs1_data;
   rs_addr_t rs2_addr;
   logic     rs2_used;
   xdata_t   rs2_data;
   logic     issue_en;
   rs_addr_t issue_rd;
   logic     issue_rd_en;
   logic     flush;
   logic     hazard;
   logic     issue_fire;

   modport master (
      output wb_en, wb_addr, wb_data,
      output rs1_addr, rs1_used, rs2_addr, rs2_used,
      output issue_en, issue_rd, issue_rd_en, flush,
      input  rs1_data, rs2_data, hazard, issue_fire
   );

   modport slave (
      input  wb_en, wb_addr, wb_data,
      input  rs1_addr, rs1_used, rs2_addr, rs2_used,
      input  issue_en, issue_rd, issue_rd_en, flush,
      output rs1_data, rs2_data, hazard, issue_fire
   );
endinterface

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
// ============================================================================
// Module : regfile_scoreboard
// Busy-bit vector with set/clear/flush and bypass-aware lookup of 3 addresses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
   import reg_file_pkg::*;
#(
   parameter bit BYPASS_EN = 1'b1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_set_en,
   input  wire rs_addr_t   i_set_addr,
   input  wire logic       i_wb_en,
   input  wire rs_addr_t   i_wb_addr,
   input  wire logic       i_flush,
   input  wire rs_addr_t   i_look_addr [3],
   output logic [2:0]      o_eff_busy
);

   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;

   // Later assignments take priority: clear, then set (newer producer), then flush.
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_wb_en && !is_zero_reg(i_wb_addr))
         w_busy_nxt[i_wb_addr] = 1'b0;
      if (i_set_en && !is_zero_reg(i_set_addr))
         w_busy_nxt[i_set_addr] = 1'b1;
      if (i_flush)
         w_busy_nxt = '0;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   for (genvar k = 0; k < 3; k++) begin : g_look
      logic w_byp_hit;
      assign w_byp_hit     = BYPASS_EN && i_wb_en && (i_wb_addr == i_look_addr[k]);
      assign o_eff_busy[k] = r_busy[i_look_addr[k]] & ~w_byp_hit;
   end

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module : reg_file
// Integer register file: 2 combinational read ports, 1 write port, RAW/WAW
// hazard detection from a busy-bit scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file
   import reg_file_pkg::*;
#(
   parameter bit BYPASS_EN = 1'b1
) (
   input  wire logic clk,
   input  wire logic rst,
   reg_file_if.slave bus
);

   xdata_t   r_regs [NREGS];
   logic     w_wb_write;
   logic     w_hazard;
   logic     w_fire;
   logic     w_set_en;
   logic [2:0] w_eff_busy;
   rs_addr_t w_look_addr [3];

   assign w_wb_write = bus.wb_en && !is_zero_reg(bus.wb_addr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            r_regs[i] <= '0;
      end else if (w_wb_write) begin
         r_regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   function automatic xdata_t read_mux(input logic     in_rst,
                                       input rs_addr_t a,
                                       input logic     wb_en,
                                       input rs_addr_t wb_addr,
                                       input xdata_t   wb_data,
                                       input xdata_t   stored);
      if (in_rst || is_zero_reg(a))
         return '0;
      else if (BYPASS_EN && wb_en && (wb_addr == a))
         return wb_data;
      else
         return stored;
   endfunction

   assign bus.rs1_data = read_mux(rst, bus.rs1_addr, bus.wb_en, bus.wb_addr,
                                  bus.wb_data, r_regs[bus.rs1_addr]);
   assign bus.rs2_data = read_mux(rst, bus.rs2_addr, bus.wb_en, bus.wb_addr,
                                  bus.wb_data, r_regs[bus.rs2_addr]);

   assign w_look_addr[0] = bus.rs1_addr;
   assign w_look_addr[1] = bus.rs2_addr;
   assign w_look_addr[2] = bus.issue_rd;

   // Third lookup is the WAW check on the issuing destination.
   assign w_hazard = ~rst & ((bus.rs1_used    & w_eff_busy[0]) |
                             (bus.rs2_used    & w_eff_busy[1]) |
                             (bus.issue_rd_en & w_eff_busy[2]));
   assign w_fire   = ~rst & bus.issue_en & ~w_hazard & ~bus.flush;
   assign w_set_en = w_fire & bus.issue_rd_en;

   assign bus.hazard     = w_hazard;
   assign bus.issue_fire = w_fire;

   regfile_scoreboard #(
      .BYPASS_EN (BYPASS_EN)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .i_set_en    (w_set_en),
      .i_set_addr  (bus.issue_rd),
      .i_wb_en     (bus.wb_en),
      .i_wb_addr   (bus.wb_addr),
      .i_flush     (bus.flush),
      .i_look_addr (w_look_addr),
      .o_eff_busy  (w_eff_busy)
   );

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module : tb_reg_file
// Directed scenarios plus random traffic against an array-based reference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   reg_file_if bus ();

   reg_file #(.BYPASS_EN(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference state: plain arrays indexed by register number.
   logic [31:0] m_regs [32];
   bit          m_busy [32];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (rst || a == 5'd0) return 32'd0;
      if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
      return m_regs[a];
   endfunction

   function automatic bit exp_busy(input logic [4:0] a);
      return (a != 5'd0) && m_busy[a] && !(bus.wb_en && bus.wb_addr == a);
   endfunction

   function automatic bit exp_hazard();
      if (rst) return 1'b0;
      return (bus.rs1_used && exp_busy(bus.rs1_addr)) ||
             (bus.rs2_used && exp_busy(bus.rs2_addr)) ||
             (bus.issue_rd_en && exp_busy(bus.issue_rd));
   endfunction

   function automatic bit exp_fire();
      return !rst && bus.issue_en && !exp_hazard() && !bus.flush;
   endfunction

   always @(posedge clk) begin : model_update
      bit f;
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
         end
      end else begin
         f = exp_fire();
         if (bus.wb_en && bus.wb_addr != 5'd0) begin
            m_regs[bus.wb_addr] = bus.wb_data;
            m_busy[bus.wb_addr] = 1'b0;
         end
         if (bus.flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         end else if (f && bus.issue_rd_en && bus.issue_rd != 5'd0) begin
            m_busy[bus.issue_rd] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin : compare
      chk("rs1_data",   bus.rs1_data,           exp_read(bus.rs1_addr));
      chk("rs2_data",   bus.rs2_data,           exp_read(bus.rs2_addr));
      chk("hazard",     32'(bus.hazard),        32'(exp_hazard()));
      chk("issue_fire", 32'(bus.issue_fire),    32'(exp_fire()));
   end

   task automatic idle();
      bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
      bus.rs1_addr = '0; bus.rs1_used = 0; bus.rs2_addr = '0; bus.rs2_used = 0;
      bus.issue_en = 0; bus.issue_rd = '0; bus.issue_rd_en = 0; bus.flush = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic issue(input logic [4:0] rd);
      bus.issue_en = 1; bus.issue_rd = rd; bus.issue_rd_en = 1;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      bus.wb_en = 1; bus.wb_addr = a; bus.wb_data = d;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'd0;
         m_busy[i] = 1'b0;
      end
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // Bypass then storage read of x5
      next_cycle(); wb(5'd5, 32'hDEAD_BEEF); bus.rs1_addr = 5'd5;
      @(negedge clk); chk("t2_bypass", bus.rs1_data, 32'hDEAD_BEEF);
      next_cycle(); bus.rs1_addr = 5'd5;
      @(negedge clk); chk("t2_stored", bus.rs1_data, 32'hDEAD_BEEF);

      // x0 write dropped
      next_cycle(); wb(5'd0, 32'h1234); bus.rs1_addr = 5'd0;
      @(negedge clk); chk("t3_x0_same", bus.rs1_data, 32'd0);
      next_cycle(); bus.rs1_addr = 5'd0;
      @(negedge clk); chk("t3_x0_next", bus.rs1_data, 32'd0);

      // RAW stall on x7 until writeback
      next_cycle(); issue(5'd7);
      @(negedge clk); chk("t4_issue", 32'(bus.issue_fire), 32'd1);
      for (int c = 0; c < 2; c++) begin
         next_cycle(); bus.issue_en = 1; bus.rs2_used = 1; bus.rs2_addr = 5'd7;
         @(negedge clk);
         chk("t4_stall_hz", 32'(bus.hazard), 32'd1);
         chk("t4_stall_fire", 32'(bus.issue_fire), 32'd0);
      end
      next_cycle(); bus.issue_en = 1; bus.rs2_used = 1; bus.rs2_addr = 5'd7;
      wb(5'd7, 32'h0000_0077);
      @(negedge clk);
      chk("t4_wb_hz", 32'(bus.hazard), 32'd0);
      chk("t4_wb_data", bus.rs2_data, 32'h0000_0077);
      chk("t4_wb_fire", 32'(bus.issue_fire), 32'd1);

      // Set beats clear on x9
      next_cycle(); issue(5'd9); wb(5'd9, 32'h99);
      @(negedge clk); chk("t5_fire", 32'(bus.issue_fire), 32'd1);
      next_cycle(); bus.rs1_used = 1; bus.rs1_addr = 5'd9;
      @(negedge clk); chk("t5_hazard", 32'(bus.hazard), 32'd1);
      next_cycle(); wb(5'd9, 32'h999);

      // Flush clears x3/x4 busy; later wb to x3 updates data only
      next_cycle(); issue(5'd3);
      next_cycle(); issue(5'd4);
      next_cycle(); bus.rs1_used = 1; bus.rs1_addr = 5'd3;
      @(negedge clk); chk("t6_busy3", 32'(bus.hazard), 32'd1);
      next_cycle(); bus.flush = 1; issue(5'd5);
      @(negedge clk); chk("t6_flush_fire", 32'(bus.issue_fire), 32'd0);
      next_cycle(); bus.rs1_used = 1; bus.rs1_addr = 5'd3;
      bus.rs2_used = 1; bus.rs2_addr = 5'd4; bus.issue_en = 1; bus.issue_rd = 5'd5;
      bus.issue_rd_en = 1;
      @(negedge clk);
      chk("t6_after_hz", 32'(bus.hazard), 32'd0);
      chk("t6_after_fire", 32'(bus.issue_fire), 32'd1);
      next_cycle(); wb(5'd3, 32'h33);
      next_cycle(); bus.rs1_used = 1; bus.rs1_addr = 5'd3;
      @(negedge clk);
      chk("t6_x3_data", bus.rs1_data, 32'h33);
      chk("t6_x3_hz", 32'(bus.hazard), 32'd0);

      // Asynchronous reset mid-run with state present
      next_cycle(); issue(5'd10);
      next_cycle(); bus.rs1_used = 1; bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd5;
      @(negedge clk);
      chk("t1_pre_hz", 32'(bus.hazard), 32'd1);
      chk("t1_pre_data", bus.rs2_data, 32'hDEAD_BEEF);
      @(posedge clk); #2 rst = 1; #1;
      chk("t1_rst_data", bus.rs2_data, 32'd0);
      chk("t1_rst_hz", 32'(bus.hazard), 32'd0);
      @(posedge clk); #1 rst = 0;
      @(negedge clk); chk("t1_post_data", bus.rs2_data, 32'd0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         rst             = ($urandom_range(0, 299) == 0);
         bus.wb_en       = ($urandom_range(0, 9) < 4);
         bus.wb_addr     = 5'($urandom_range(0, 9) < 8 ? $urandom_range(0, 7) : $urandom_range(0, 31));
         bus.wb_data     = $urandom;
         bus.rs1_addr    = 5'($urandom_range(0, 7));
         bus.rs1_used    = $urandom_range(0, 1) == 1;
         bus.rs2_addr    = 5'($urandom_range(0, 9) < 8 ? $urandom_range(0, 7) : $urandom_range(0, 31));
         bus.rs2_used    = $urandom_range(0, 1) == 1;
         bus.issue_en    = $urandom_range(0, 1) == 1;
         bus.issue_rd    = 5'($urandom_range(0, 7));
         bus.issue_rd_en = ($urandom_range(0, 3) != 0);
         bus.flush       = ($urandom_range(0, 29) == 0);
      end
      @(posedge clk); #1; rst = 0; idle();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
